// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared definitions for the HD44780 display-side responder: instruction
// opcodes, DDRAM constants and the mode/control state encodings.
package lcd_pkg;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_ENTRY    = 8'h04;
  localparam logic [7:0] OP_DISPLAY  = 8'h08;
  localparam logic [7:0] OP_FUNCSET  = 8'h20;
  localparam logic [7:0] OP_SETDDRAM = 8'h80;

  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [7:0] SPACE      = 8'h20;

  typedef enum logic [1:0] {
    INIT8  = 2'd0,
    NIB_HI = 2'd1,
    NIB_LO = 2'd2
  } mode_e;

  typedef enum logic {
    CTL_IDLE  = 1'b0,
    CTL_CLEAR = 1'b1
  } ctl_e;

  typedef struct packed {
    ctl_e  ctl;
    mode_e mode;
  } dbg_state_t;

  // Instructions are decoded by their highest set bit; this returns it one-hot.
  function automatic logic [7:0] top_bit(input logic [7:0] b);
    top_bit = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) top_bit = 8'h01 << i;
    end
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// 4-bit HD44780 bus as seen from the driver (master) and the display (slave).
// A transfer happens on the falling edge of iLcdE; iLcdRs, iLcdRw and
// iLcdData must be stable across that edge. There is no back-pressure.
interface lcd_hd44780_responder_if;
  logic       iLcdRs;
  logic       iLcdRw;
  logic       iLcdE;
  logic [3:0] iLcdData;

  modport master (output iLcdRs, output iLcdRw, output iLcdE, output iLcdData);
  modport slave  (input  iLcdRs, input  iLcdRw, input  iLcdE, input  iLcdData);
endinterface

// File: rtl/lcd_hd44780_responder_bus_sync.sv
// Synchronizes the LCD bus into the Clock domain and detects the falling
// edge of E; RS/RW/data come out of the same stage so they align with strobe.
module lcd_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  input  logic [3:0] data,
  output logic       strobe,
  output logic       rs_s,
  output logic       rw_s,
  output logic [3:0] data_s
);

  // Packed as {rs, rw, e, data[3:0]}.
  logic [6:0] pipe [STAGES];
  logic       e_prev;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      e_prev <= 1'b0;
    end else begin
      pipe[0] <= {rs, rw, e, data};
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      e_prev <= pipe[STAGES-1][4];
    end
  end

  assign rs_s   = pipe[STAGES-1][6];
  assign rw_s   = pipe[STAGES-1][5];
  assign data_s = pipe[STAGES-1][3:0];
  assign strobe = e_prev & ~pipe[STAGES-1][4];

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display-side HD44780 model: runs the 8-bit/4-bit power-on handshake,
// assembles bytes, executes the driver's instruction subset and holds DDRAM.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int LINE_LEN    = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  lcd_hd44780_responder_if.slave  lcd,
  input  logic [6:0]              iReadIndex,
  output logic [7:0]              oReadChar,
  output logic [6:0]              oAddr,
  output logic                    oFourBit,
  output logic                    oDisplayOn,
  output logic                    oBusy,
  output logic                    oByteValid,
  output logic [7:0]              oByte,
  output logic                    oByteRs,
  output logic                    oError,
  output dbg_state_t              oDbgState
);

  localparam int         DEPTH    = 2 * LINE_LEN;
  localparam logic [6:0] LAST1    = 7'(LINE_LEN - 1);
  localparam logic [6:0] LAST2    = LINE2_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] DEPTH_M1 = 7'(DEPTH - 1);

  logic       strobe, rs_s, rw_s;
  logic [3:0] data_s;

  lcd_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .rs     (lcd.iLcdRs),
    .rw     (lcd.iLcdRw),
    .e      (lcd.iLcdE),
    .data   (lcd.iLcdData),
    .strobe (strobe),
    .rs_s   (rs_s),
    .rw_s   (rw_s),
    .data_s (data_s)
  );

  mode_e      mode;
  ctl_e       ctl;
  logic [6:0] clr_idx;
  logic       entry_inc;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic [7:0] ddram [DEPTH];

  function automatic logic [6:0] index_of(input logic [6:0] a);
    return a[6] ? 7'(LINE_LEN) + {1'b0, a[5:0]} : {1'b0, a[5:0]};
  endfunction

  function automatic logic addr_legal(input logic [6:0] a);
    return 32'(a[5:0]) < LINE_LEN;
  endfunction

  // The address counter wraps line 0 end <-> line 1 start in both directions.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LAST1) return LINE2_BASE;
      if (a == LAST2) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00)      return LAST2;
    if (a == LINE2_BASE) return LAST1;
    return a - 7'd1;
  endfunction

  logic       reject, rs_mismatch, assembled, exec_valid, exec_rs, addr_err;
  logic [7:0] exec_byte;

  always_comb begin
    reject      = 1'b0;
    rs_mismatch = 1'b0;
    assembled   = 1'b0;
    exec_valid  = 1'b0;
    exec_rs     = 1'b0;
    exec_byte   = 8'h00;
    if (strobe) begin
      if (rw_s || ctl == CTL_CLEAR) begin
        reject = 1'b1;
      end else begin
        case (mode)
          INIT8: begin
            if (data_s != 4'h3 && data_s != 4'h2) begin
              exec_valid = 1'b1;
              exec_byte  = {data_s, 4'h0};
            end
          end
          NIB_LO: begin
            if (rs_s != hi_rs) begin
              rs_mismatch = 1'b1;
            end else begin
              assembled  = 1'b1;
              exec_valid = 1'b1;
              exec_rs    = rs_s;
              exec_byte  = {hi_nib, data_s};
            end
          end
          default: ;
        endcase
      end
    end
    addr_err = exec_valid && !exec_rs && exec_byte[7] && !addr_legal(exec_byte[6:0]);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mode       <= INIT8;
      ctl        <= CTL_CLEAR;
      clr_idx    <= 7'd0;
      entry_inc  <= 1'b1;
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      oAddr      <= 7'h00;
      oDisplayOn <= 1'b0;
      oByteValid <= 1'b0;
      oByte      <= 8'h00;
      oByteRs    <= 1'b0;
      oError     <= 1'b0;
    end else begin
      oByteValid <= assembled;
      oError     <= reject | rs_mismatch | addr_err;
      if (assembled) begin
        oByte   <= exec_byte;
        oByteRs <= exec_rs;
      end

      if (ctl == CTL_CLEAR) begin
        if (clr_idx == DEPTH_M1) begin
          ctl       <= CTL_IDLE;
          clr_idx   <= 7'd0;
          oAddr     <= 7'h00;
          entry_inc <= 1'b1;
        end else begin
          clr_idx <= clr_idx + 7'd1;
        end
      end

      if (strobe && !reject) begin
        case (mode)
          INIT8:   if (data_s == 4'h2) mode <= NIB_HI;
          NIB_HI: begin
            hi_nib <= data_s;
            hi_rs  <= rs_s;
            mode   <= NIB_LO;
          end
          NIB_LO:  mode <= NIB_HI;
          default: mode <= INIT8;
        endcase
      end

      if (exec_valid) begin
        if (exec_rs) begin
          oAddr <= step_addr(oAddr, entry_inc);
        end else begin
          case (top_bit(exec_byte))
            OP_SETDDRAM: if (!addr_err) oAddr <= exec_byte[6:0];
            OP_FUNCSET:  if (exec_byte[4]) mode <= INIT8;
            OP_DISPLAY:  oDisplayOn <= exec_byte[2];
            OP_ENTRY:    entry_inc <= exec_byte[1];
            OP_HOME:     oAddr <= 7'h00;
            OP_CLEAR: begin
              ctl     <= CTL_CLEAR;
              clr_idx <= 7'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic       mem_we;
  logic [6:0] mem_idx;
  logic [7:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = 7'd0;
    mem_wdata = 8'h00;
    if (ctl == CTL_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx;
      mem_wdata = SPACE;
    end else if (exec_valid && exec_rs) begin
      mem_we    = 1'b1;
      mem_idx   = index_of(oAddr);
      mem_wdata = exec_byte;
    end
  end

  // DDRAM contents are not reset; the post-reset clear fills them with spaces.
  always_ff @(posedge Clock) begin
    if (mem_we) ddram[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oReadChar <= 8'h00;
    end else if ({1'b0, iReadIndex} < 8'(DEPTH)) begin
      oReadChar <= ddram[iReadIndex];
    end else begin
      oReadChar <= 8'h00;
    end
  end

  assign oFourBit  = (mode != INIT8);
  assign oBusy     = (ctl == CTL_CLEAR);
  assign oDbgState = '{ctl: ctl, mode: mode};

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench: drives the HD44780 bus with directed and random
// traffic and compares against a line/column display model.
module tb_lcd_hd44780_responder;
  import lcd_pkg::*;

  localparam int LEN   = 40;
  localparam int DEPTH = 2 * LEN;

  // clock / reset
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  lcd_hd44780_responder_if lcd_bus ();
  logic [6:0] iReadIndex;
  logic [7:0] oReadChar;
  logic [6:0] oAddr;
  logic       oFourBit, oDisplayOn, oBusy, oByteValid, oByteRs, oError;
  logic [7:0] oByte;
  dbg_state_t oDbgState;

  lcd_hd44780_responder #(.LINE_LEN(LEN), .SYNC_STAGES(2)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .lcd        (lcd_bus),
    .iReadIndex (iReadIndex),
    .oReadChar  (oReadChar),
    .oAddr      (oAddr),
    .oFourBit   (oFourBit),
    .oDisplayOn (oDisplayOn),
    .oBusy      (oBusy),
    .oByteValid (oByteValid),
    .oByte      (oByte),
    .oByteRs    (oByteRs),
    .oError     (oError),
    .oDbgState  (oDbgState)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference model: text grid indexed by line and column
  logic [7:0] m_ram [DEPTH];
  int   m_line, m_col;
  bit   m_inc, m_four, m_hi, m_disp, m_busy;
  logic [3:0] m_hn;
  logic       m_hrs;
  int   exp_err = 0;
  int   got_err = 0;
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];

  function automatic int m_addr();
    return m_line * 64 + m_col;
  endfunction

  task automatic m_blank();
    for (int i = 0; i < DEPTH; i++) m_ram[i] = 8'h20;
    m_line = 0;
    m_col  = 0;
    m_inc  = 1;
  endtask

  task automatic m_reset();
    m_blank();
    m_four = 0;
    m_hi   = 1;
    m_disp = 0;
    m_busy = 1;
  endtask

  task automatic m_step();
    if (m_inc) begin
      m_col++;
      if (m_col == LEN) begin m_col = 0; m_line = 1 - m_line; end
    end else if (m_col == 0) begin
      m_col = LEN - 1;
      m_line = 1 - m_line;
    end else begin
      m_col--;
    end
  endtask

  task automatic m_exec(input logic rs, input logic [7:0] b);
    if (rs) begin
      m_ram[m_line * LEN + m_col] = b;
      m_step();
    end else if (b[7]) begin
      int a;
      a = int'(b[6:0]);
      if ((a % 64) < LEN) begin m_line = a / 64; m_col = a % 64; end
      else exp_err++;
    end else if (b[6]) begin
    end else if (b[5]) begin
      if (b[4]) begin m_four = 0; m_hi = 1; end
    end else if (b[4]) begin
    end else if (b[3]) begin
      m_disp = b[2];
    end else if (b[2]) begin
      m_inc = b[1];
    end else if (b[1]) begin
      m_line = 0;
      m_col  = 0;
    end else if (b[0]) begin
      m_busy = 1;
      m_blank();
    end
  endtask

  task automatic m_strobe(input logic rs, input logic rw, input logic [3:0] d);
    if (rw || m_busy) begin
      exp_err++;
    end else if (!m_four) begin
      if (d == 4'h2) begin m_four = 1; m_hi = 1; end
      else if (d != 4'h3) m_exec(1'b0, {d, 4'h0});
    end else if (m_hi) begin
      m_hn  = d;
      m_hrs = rs;
      m_hi  = 0;
    end else begin
      m_hi = 1;
      if (rs != m_hrs) exp_err++;
      else begin
        exp_q.push_back({rs, m_hn, d});
        m_exec(rs, {m_hn, d});
      end
    end
  endtask

  // driver tasks
  task automatic send_nib(input logic rs, input logic rw, input logic [3:0] d);
    @(negedge Clock);
    lcd_bus.iLcdRs   = rs;
    lcd_bus.iLcdRw   = rw;
    lcd_bus.iLcdData = d;
    lcd_bus.iLcdE    = 1'b1;
    repeat (3) @(negedge Clock);
    lcd_bus.iLcdE    = 1'b0;
    repeat (6) @(negedge Clock);
    m_strobe(rs, rw, d);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nib(rs, 1'b0, b[7:4]);
    send_nib(rs, 1'b0, b[3:0]);
  endtask

  task automatic read_ram(input int idx, output logic [7:0] v);
    @(negedge Clock);
    iReadIndex = 7'(idx);
    @(negedge Clock);
    v = oReadChar;
  endtask

  task automatic check_ram(input string tag);
    logic [7:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      read_ram(i, v);
      check($sformatf("%s_ram%0d", tag, i), v, m_ram[i]);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_addr"}, oAddr, m_addr());
    check({tag, "_four"}, oFourBit, m_four);
    check({tag, "_disp"}, oDisplayOn, m_disp);
    check({tag, "_busy"}, oBusy, 1'b0);
  endtask

  // scoreboard
  always @(negedge Clock) begin
    if (oByteValid === 1'b1) got_q.push_back({oByteRs, oByte});
    if (oError === 1'b1) got_err++;
  end

  task automatic scoreboard(input string tag);
    logic [8:0] g, e;
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_byte"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_errs"}, got_err, exp_err);
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (oBusy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge Clock);
    end
    m_busy = 0;
    check("clear_done", oBusy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    logic [7:0] v;
    lcd_bus.iLcdRs   = 1'b0;
    lcd_bus.iLcdRw   = 1'b0;
    lcd_bus.iLcdE    = 1'b0;
    lcd_bus.iLcdData = 4'h0;
    iReadIndex       = 7'd0;
    m_reset();
    repeat (4) @(negedge Clock);
    check("rst_addr", oAddr, 7'h00);
    check("rst_four", oFourBit, 1'b0);
    check("rst_disp", oDisplayOn, 1'b0);
    check("rst_busy", oBusy, 1'b1);
    check("rst_bv", oByteValid, 1'b0);
    check("rst_err", oError, 1'b0);
    check("rst_byte", oByte, 8'h00);
    check("rst_rd", oReadChar, 8'h00);

    Reset = 1'b1;
    wait_clear(cnt);
    check("busy_len", cnt, DEPTH);
    check_ram("init");
    check_state("init");

    // power-on handshake
    send_nib(0, 0, 4'h3);
    send_nib(0, 0, 4'h3);
    send_nib(0, 0, 4'h3);
    check("pwr_four_pre", oFourBit, 1'b0);
    send_nib(0, 0, 4'h2);
    check("pwr_four", oFourBit, 1'b1);
    scoreboard("pwr");

    send_byte(0, 8'h28);
    send_byte(0, 8'h06);
    send_byte(0, 8'h0C);
    send_byte(1, 8'h48);
    scoreboard("init_seq");
    check_state("init_seq");
    read_ram(0, v);
    check("ram0_H", v, 8'h48);

    send_byte(0, 8'hA7);
    send_byte(1, 8'h41);
    send_byte(1, 8'h42);
    read_ram(39, v);
    check("ram39_A", v, 8'h41);
    read_ram(40, v);
    check("ram40_B", v, 8'h42);
    check("addr_wrap", oAddr, 7'h41);
    send_byte(0, 8'hC0);
    send_byte(1, 8'h5A);
    read_ram(40, v);
    check("ram40_Z", v, 8'h5A);
    check_state("wrap");

    // rejects: RW read, illegal address, RS mismatch
    send_nib(0, 1, 4'h4);
    send_byte(0, 8'hB0);
    send_nib(0, 0, 4'h4);
    send_nib(1, 0, 4'h1);
    check_state("rej");
    scoreboard("rej");

    // strobe while the clear is running
    send_byte(0, 8'h01);
    send_nib(1, 0, 4'h5);
    wait_clear(cnt);
    check_ram("clr");
    check_state("clr");
    scoreboard("clr");

    // line strings, driver style
    send_byte(0, 8'h80);
    for (int i = 0; i < 32; i++) send_byte(1, 8'($urandom_range(32, 126)));
    send_byte(0, 8'hC0);
    for (int i = 0; i < 32; i++) send_byte(1, 8'($urandom_range(32, 126)));
    check_ram("lines");
    check_state("lines");
    scoreboard("lines");

    // DL=1 returns to 8-bit mode, then back to 4-bit
    send_byte(0, 8'h30);
    check("dl8_four", oFourBit, 1'b0);
    send_nib(0, 0, 4'h2);
    check("dl4_four", oFourBit, 1'b1);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: send_byte(1, 8'($urandom_range(0, 255)));
        5: send_byte(0, 8'h80 | 8'($urandom_range(0, 127)));
        6: send_byte(0, 8'h04 | 8'($urandom_range(0, 3)));
        7: send_byte(0, 8'h08 | 8'($urandom_range(0, 7)));
        8: send_byte(0, 8'h02);
        default: begin
          if ($urandom_range(0, 1) == 0) send_nib(1'($urandom_range(0, 1)), 1, 4'($urandom_range(0, 15)));
          else begin
            send_nib(0, 0, 4'($urandom_range(0, 15)));
            send_nib(1, 0, 4'($urandom_range(0, 15)));
          end
        end
      endcase
      if (n % 20 == 19) begin
        check_state($sformatf("rand%0d", n));
        scoreboard($sformatf("rand%0d", n));
      end
    end
    check_ram("rand");

    // reset in the middle of a byte
    send_nib(1, 0, 4'h4);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    m_reset();
    check("mrst_four", oFourBit, 1'b0);
    check("mrst_busy", oBusy, 1'b1);
    check("mrst_addr", oAddr, 7'h00);
    check("mrst_disp", oDisplayOn, 1'b0);
    Reset = 1'b1;
    wait_clear(cnt);
    check("busy_len2", cnt, DEPTH);
    check_ram("mrst");
    check_state("mrst");
    scoreboard("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
